// File: rtl/ikaopm_slotgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ikaopm_slotgen: phi1/reset/slot timing with programmable decode taps     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ikaopm_slotgen #(
  parameter int SLOT_BITS   = 5,
  parameter int SYNC_STAGES = 4,
  parameter int PHI_DIV     = 2,
  parameter int NUM_TAPS    = 8,
  parameter int SH_DELAY    = 5,
  localparam int ADDR_W     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
  localparam int TAP_W      = SLOT_BITS + 2
) (
  input  logic                 i_EMUCLK,
  input  logic                 i_RST,
  input  logic                 i_IC_n,
  input  logic                 i_phiM_PCEN_n,
  output logic                 o_MRST_n,
  output logic                 o_phi1,
  output logic                 o_phi1_PCEN_n,
  output logic                 o_phi1_NCEN_n,
  output logic [SLOT_BITS-1:0] o_SLOT,
  output logic                 o_FRAME,
  input  logic                 i_TAP_WR,
  input  logic [ADDR_W-1:0]    i_TAP_ADDR,
  input  logic [TAP_W-1:0]     i_TAP_DATA,
  output logic                 o_TAP_PEND,
  output logic [NUM_TAPS-1:0]  o_TAP,
  output logic                 o_SH1,
  output logic                 o_SH2
);

  localparam int PHI_W = $clog2(PHI_DIV);
  localparam logic [PHI_W-1:0]     c_P_LAST   = PHI_W'(PHI_DIV - 1);
  localparam logic [PHI_W-1:0]     c_P_FALL   = PHI_W'(PHI_DIV / 2 - 1);
  localparam logic [PHI_W-1:0]     c_P_HALF   = PHI_W'(PHI_DIV / 2);
  localparam logic [SLOT_BITS-1:0] c_SLOT_MAX = '1;
  localparam logic [SLOT_BITS-1:0] c_MIRROR   = {1'b1, {(SLOT_BITS-1){1'b0}}};

  logic                   w_phim_en, w_pcen, w_ncen, w_commit, w_wr_any;
  logic                   w_sh1, w_sh2;
  logic [SYNC_STAGES-1:0] r_sr;
  logic                   r_negedge;
  logic [PHI_W-1:0]       r_phase;
  logic                   r_mrst_n, r_frame, r_pend, r_sh1, r_sh2;
  logic [SLOT_BITS-1:0]   r_slot;
  logic [NUM_TAPS-1:0]    r_tap, w_tap_hit, w_wr_sel;
  logic [SH_DELAY-1:0]    r_sh1_sr, r_sh2_sr;
  logic [TAP_W-1:0]       r_shadow [NUM_TAPS];
  logic [TAP_W-1:0]       r_active [NUM_TAPS];

  assign w_phim_en = ~i_phiM_PCEN_n;
  // The negedge flag swallows one phi1 edge pair so phi1 restarts at phase 0.
  assign w_pcen    = w_phim_en & ~r_negedge & (r_phase == c_P_LAST);
  assign w_ncen    = w_phim_en & ~r_negedge & (r_phase == c_P_FALL);
  assign w_commit  = w_ncen & (r_slot == c_SLOT_MAX);
  assign w_sh1     = (r_slot[SLOT_BITS-1:SLOT_BITS-2] == 2'b01);
  assign w_sh2     = (r_slot[SLOT_BITS-1:SLOT_BITS-2] == 2'b11);
  assign w_wr_any  = |w_wr_sel;

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      r_sr      <= '0;
      r_negedge <= 1'b0;
      r_phase   <= '0;
    end else if (w_phim_en) begin
      r_sr[0] <= i_IC_n;
      for (int i = 1; i < SYNC_STAGES; i++) r_sr[i] <= r_sr[i-1];
      r_negedge <= ~r_sr[SYNC_STAGES-2] & r_sr[SYNC_STAGES-1];
      if (r_negedge || (r_phase == c_P_LAST)) r_phase <= '0;
      else                                    r_phase <= r_phase + PHI_W'(1);
    end
  end

  always_comb begin
    w_wr_sel  = '0;
    w_tap_hit = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      w_wr_sel[k]  = i_TAP_WR & (i_TAP_ADDR == ADDR_W'(k));
      w_tap_hit[k] = r_mrst_n & r_active[k][TAP_W-1] &
                     ((r_slot == r_active[k][SLOT_BITS-1:0]) |
                      (r_active[k][SLOT_BITS] &
                       (r_slot == (r_active[k][SLOT_BITS-1:0] ^ c_MIRROR))));
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      r_mrst_n <= 1'b0;
      r_slot   <= '0;
      r_frame  <= 1'b0;
      r_tap    <= '0;
      r_sh1_sr <= '0;
      r_sh2_sr <= '0;
      r_sh1    <= 1'b0;
      r_sh2    <= 1'b0;
    end else if (w_ncen) begin
      r_mrst_n <= r_sr[SYNC_STAGES-2];
      r_slot   <= r_mrst_n ? r_slot + SLOT_BITS'(1) : '0;
      r_frame  <= (r_slot == c_SLOT_MAX);
      r_tap    <= w_tap_hit;
      r_sh1_sr[0] <= w_sh1;
      r_sh2_sr[0] <= w_sh2;
      for (int i = 1; i < SH_DELAY; i++) begin
        r_sh1_sr[i] <= r_sh1_sr[i-1];
        r_sh2_sr[i] <= r_sh2_sr[i-1];
      end
      r_sh1 <= r_sh1_sr[SH_DELAY-1] & r_mrst_n;
      r_sh2 <= r_sh2_sr[SH_DELAY-1] & r_mrst_n;
    end
  end

  // A write coinciding with commit lands in the shadow only, so it stays pending.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
      r_pend <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (w_wr_sel[k]) r_shadow[k] <= i_TAP_DATA;
        if (w_commit)    r_active[k] <= r_shadow[k];
      end
      if (w_commit)      r_pend <= w_wr_any;
      else if (w_wr_any) r_pend <= 1'b1;
    end
  end

  assign o_MRST_n      = r_mrst_n;
  assign o_phi1        = (r_phase < c_P_HALF);
  assign o_phi1_PCEN_n = ~w_pcen;
  assign o_phi1_NCEN_n = ~w_ncen;
  assign o_SLOT        = r_slot;
  assign o_FRAME       = r_frame;
  assign o_TAP_PEND    = r_pend;
  assign o_TAP         = r_tap;
  assign o_SH1         = r_sh1;
  assign o_SH2         = r_sh2;

endmodule
`default_nettype wire

// File: tb/tb_ikaopm_slotgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ikaopm_slotgen: directed bench for ikaopm_slotgen (PHI_DIV=4, 6 taps) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ikaopm_slotgen;

  logic       clk = 1'b0;
  logic       rst, ic_n, pm_n, tap_wr;
  logic [2:0] tap_addr;
  logic [6:0] tap_data;
  logic       mrst_n, phi1, pcen_n, ncen_n, frame, pend, sh1, sh2;
  logic [4:0] slot;
  logic [5:0] tap;

  int n_vec = 0;
  int n_err = 0;
  bit last_ncen, last_pcen, last_phi1_b, last_phi1_a;
  bit wr_on_ncen;
  logic [2:0] wr_addr;
  logic [6:0] wr_data;

  ikaopm_slotgen #(
    .SLOT_BITS(5), .SYNC_STAGES(4), .PHI_DIV(4), .NUM_TAPS(6), .SH_DELAY(5)
  ) dut (
    .i_EMUCLK(clk), .i_RST(rst), .i_IC_n(ic_n), .i_phiM_PCEN_n(pm_n),
    .o_MRST_n(mrst_n), .o_phi1(phi1), .o_phi1_PCEN_n(pcen_n), .o_phi1_NCEN_n(ncen_n),
    .o_SLOT(slot), .o_FRAME(frame), .i_TAP_WR(tap_wr), .i_TAP_ADDR(tap_addr),
    .i_TAP_DATA(tap_data), .o_TAP_PEND(pend), .o_TAP(tap), .o_SH1(sh1), .o_SH2(sh2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One phiM enable clock followed by one idle clock.
  task automatic pm_step();
    pm_n = 1'b0;
    #1;
    last_ncen   = ~ncen_n;
    last_pcen   = ~pcen_n;
    last_phi1_b = phi1;
    if (wr_on_ncen && last_ncen) begin
      tap_wr = 1'b1; tap_addr = wr_addr; tap_data = wr_data;
    end
    @(posedge clk); #1;
    tap_wr = 1'b0;
    if (last_ncen) wr_on_ncen = 1'b0;
    last_phi1_a = phi1;
    pm_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_ncen(input string tag);
    int k;
    k = 0;
    do begin
      pm_step();
      k++;
    end while (!last_ncen && k < 8);
    if (!last_ncen) check({tag, "_ncen_timeout"}, 32'(last_ncen), 1);
  endtask

  task automatic goto_slot(input int target);
    for (int g = 0; g < 40 && 32'(slot) != target; g++) wait_ncen("goto");
    check("goto_slot", 32'(slot), 32'(target));
  endtask

  task automatic tap_write(input logic [2:0] a, input logic [6:0] d);
    pm_n = 1'b1; tap_wr = 1'b1; tap_addr = a; tap_data = d;
    @(posedge clk); #1;
    tap_wr = 1'b0;
  endtask

  // Walk one full frame from o_SLOT==0; tN arguments are the o_SLOT values at which that tap is high.
  task automatic walk_frame(input int f, input int t1, input int t2, input int t5a, input int t5b);
    logic [5:0] exp_tap;
    for (int s = 0; s < 32; s++) begin
      if (s > 0) wait_ncen("walk");
      check($sformatf("slot_f%0d_s%0d", f, s), 32'(slot), 32'(s));
      exp_tap = '0;
      if (s == t1) exp_tap[1] = 1'b1;
      if (s == t2) exp_tap[2] = 1'b1;
      if (s == t5a || s == t5b) exp_tap[5] = 1'b1;
      check($sformatf("tap_f%0d_s%0d", f, s), 32'(tap), 32'(exp_tap));
      check($sformatf("frame_f%0d_s%0d", f, s), 32'(frame), 32'(s == 0));
      check($sformatf("sh1_f%0d_s%0d", f, s), 32'(sh1), 32'(s >= 14 && s <= 21));
      check($sformatf("sh2_f%0d_s%0d", f, s), 32'(sh2), 32'(s >= 30 || s <= 5));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] nmask, pmask;
    int hi;
    rst = 1'b0; ic_n = 1'b1; pm_n = 1'b1; tap_wr = 1'b0;
    tap_addr = '0; tap_data = '0; wr_on_ncen = 1'b0; wr_addr = '0; wr_data = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mrst", 32'(mrst_n), 0);
    check("rst_phi1", 32'(phi1), 1);
    check("rst_slot", 32'(slot), 0);
    check("rst_frame", 32'(frame), 0);
    check("rst_tap", 32'(tap), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_sh1", 32'(sh1), 0);
    check("rst_sh2", 32'(sh2), 0);
    check("rst_pcen_n", 32'(pcen_n), 1);
    check("rst_ncen_n", 32'(ncen_n), 1);
    rst = 1'b0;

    // Divider: two phi1 periods of four phiM enables each
    nmask = '0; pmask = '0; hi = 0;
    for (int i = 0; i < 8; i++) begin
      pm_step();
      nmask[i] = last_ncen;
      pmask[i] = last_pcen;
      hi += int'(last_phi1_b) + int'(last_phi1_a);
      if (i == 4) check("mrst_still_low", 32'(mrst_n), 0);
    end
    check("ncen_steps", 32'(nmask), 32'h22);
    check("pcen_steps", 32'(pmask), 32'h88);
    check("phi1_high_clks", 32'(hi), 8);
    check("mrst_up", 32'(mrst_n), 1);
    check("slot_held", 32'(slot), 0);
    pm_step();

    // IC_n low for 10 enables
    ic_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pm_step();
      if (i == 0) begin
        check("ic_l1_ncen", 32'(last_ncen), 1);
        check("ic_l1_slot", 32'(slot), 1);
      end
      if (i == 4) begin
        check("realign_no_ncen", 32'(last_ncen), 0);
        check("realign_no_pcen", 32'(last_pcen), 0);
        check("realign_phi1_b", 32'(last_phi1_b), 1);
        check("realign_phi1_a", 32'(last_phi1_a), 1);
      end
      if (i == 6) begin
        check("ic_mrst_low", 32'(mrst_n), 0);
        check("ic_slot", 32'(slot), 2);
      end
    end
    check("ic_end_phi1", 32'(phi1), 1);
    ic_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pm_step();
      if (i == 0) begin
        check("rel_r1_ncen", 32'(last_ncen), 1);
        check("rel_r1_slot", 32'(slot), 0);
        check("rel_r1_mrst", 32'(mrst_n), 0);
      end
      if (i == 3) begin
        check("rel_r4_mrst", 32'(mrst_n), 0);
        check("rel_r4_tap", 32'(tap), 0);
        check("rel_r4_sh1", 32'(sh1), 0);
        check("rel_r4_sh2", 32'(sh2), 0);
      end
      if (i == 4) begin
        check("rel_r5_ncen", 32'(last_ncen), 1);
        check("rel_r5_mrst", 32'(mrst_n), 1);
        check("rel_r5_slot", 32'(slot), 0);
      end
      if (i == 8) begin
        check("rel_r9_ncen", 32'(last_ncen), 1);
        check("rel_r9_slot", 32'(slot), 1);
      end
    end

    // Tap 2 = {en, no mirror, val 9}, written at slot 5
    goto_slot(5);
    tap_write(3'd2, 7'h49);
    check("pend_after_wr", 32'(pend), 1);
    for (int g = 0; g < 40 && slot != 5'd31; g++) begin
      wait_ncen("f0");
      check($sformatf("f0_tap_s%0d", slot), 32'(tap), 0);
      check($sformatf("f0_pend_s%0d", slot), 32'(pend), 1);
    end
    check("f0_end_slot", 32'(slot), 31);
    wait_ncen("commit0");
    check("commit0_pend", 32'(pend), 0);

    tap_write(3'd7, 7'h43);
    tap_write(3'd6, 7'h43);
    check("oor_pend", 32'(pend), 0);
    tap_write(3'd5, 7'h64);
    check("mirror_pend", 32'(pend), 1);
    walk_frame(1, -1, 10, -1, -1);
    check("f1_pend", 32'(pend), 1);
    wait_ncen("commit1");
    check("commit1_pend", 32'(pend), 0);
    walk_frame(2, -1, 10, 5, 21);

    // Write to tap 1 lands in the commit cycle
    wr_addr = 3'd1; wr_data = 7'h54; wr_on_ncen = 1'b1;
    wait_ncen("collide");
    check("collide_pend", 32'(pend), 1);
    walk_frame(3, -1, 10, 5, 21);
    check("f3_pend", 32'(pend), 1);
    wait_ncen("commit3");
    check("commit3_pend", 32'(pend), 0);
    walk_frame(4, 21, 10, 5, 21);

    // No phiM enables: only shadow writes act
    tap_write(3'd3, 7'h41);
    repeat (10) @(posedge clk);
    #1;
    check("noen_slot", 32'(slot), 31);
    check("noen_phi1", 32'(phi1), 0);
    check("noen_pend", 32'(pend), 1);
    check("noen_tap", 32'(tap), 0);
    check("noen_sh2", 32'(sh2), 1);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    check("arst_slot", 32'(slot), 0);
    check("arst_pend", 32'(pend), 0);
    check("arst_mrst", 32'(mrst_n), 0);
    check("arst_phi1", 32'(phi1), 1);
    check("arst_sh2", 32'(sh2), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
